mem_responder: RTL and testbench

- Memory-side responder for the datapath's MDR/MAR interface.
- Accepts single-word read and write requests and serves them from an internal 2^ADDR_WIDTH x DATA_WIDTH word array after a programmable number of wait states.
- Drives the Mdatain word back into MDR and signals completion with a one-cycle mem_ready pulse.
- Sits between the datapath and the control unit's memory-wait step, replacing the testbench-driven Mdatain.

---
 rtl/mem_responder.sv | 115 +++++++++++
 tb/tb_mem_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the MDR/MAR interface.
// Serves single-word reads and writes from an internal word array after
// WAIT_STATES extra cycles, then pulses mem_ready for one cycle.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    op_wr_q;
  logic [DATA_WIDTH-1:0]   mdatain_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    err_q;

  // Word array: never reset, contents survive clear.
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic access;
  logic mem_we;

  // Access happens on the edge where the wait counter has run out.
  assign access = (state_q == S_WAIT) && (cnt_q == '0);
  assign mem_we = access && op_wr_q && !clear;

  // Control FSM with registered outputs; clear aborts any pending access.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      op_wr_q   <= 1'b0;
      mdatain_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Read && Write) begin
            err_q <= 1'b1;
          end else if (Read || Write) begin
            addr_q  <= address;
            op_wr_q <= Write;
            if (Write) begin
              data_q <= data_in;
            end
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!op_wr_q) begin
              mdatain_q <= mem_q[addr_q];
            end
            ready_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // Strobes seen on this edge are deliberately ignored.
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Array write port, committed on the access edge using latched values.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign Mdatain   = mdatain_q;
  assign mem_ready = ready_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and
// one with zero wait states, sharing clock and clear.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        clear;
  logic [8:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] din;
  logic [31:0] mdatain;
  logic        mem_ready;
  logic        busy;
  logic        err;

  logic [8:0]  addr0;
  logic        rd0;
  logic        wr0;
  logic [31:0] din0;
  logic [31:0] mdatain0;
  logic        mem_ready0;
  logic        busy0;
  logic        err0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_responder #(
    .ADDR_WIDTH (9),
    .DATA_WIDTH (32),
    .WAIT_STATES(2)
  ) u_dut (
    .clock    (clock),
    .clear    (clear),
    .address  (addr),
    .Read     (rd),
    .Write    (wr),
    .data_in  (din),
    .Mdatain  (mdatain),
    .mem_ready(mem_ready),
    .busy     (busy),
    .err      (err)
  );

  mem_responder #(
    .ADDR_WIDTH (9),
    .DATA_WIDTH (32),
    .WAIT_STATES(0)
  ) u_dut0 (
    .clock    (clock),
    .clear    (clear),
    .address  (addr0),
    .Read     (rd0),
    .Write    (wr0),
    .data_in  (din0),
    .Mdatain  (mdatain0),
    .mem_ready(mem_ready0),
    .busy     (busy0),
    .err      (err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete access on the WAIT_STATES=2 instance; inputs are scrambled
  // while busy to show the latched values are used.
  task automatic xfer(input logic is_wr, input logic [8:0] a, input logic [31:0] d,
                      input string tag, output logic [31:0] rdata);
    int lat;
    rd   = !is_wr;
    wr   = is_wr;
    addr = a;
    din  = d;
    tick();
    rd   = 1'b0;
    wr   = 1'b0;
    addr = ~a;
    din  = ~d;
    chk({tag, "_busy_t0"}, 32'(busy), 32'd1);
    chk({tag, "_rdy_t0"}, 32'(mem_ready), 32'd0);
    lat = 0;
    while (mem_ready !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    rdata = mdatain;
    tick();
    chk({tag, "_done_rdy"}, 32'(mem_ready), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int cyc;
    int prev;
    int pulses;
    int rdy_seen;
    logic chk_idle;

    clear = 1'b1;
    rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0;
    tick();
    tick();
    clear = 1'b0;

    // Reset state
    chk("rst_mdatain", mdatain, 32'h0);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Write then read back
    xfer(1'b1, 9'h045, 32'hDEADBEEF, "wr045", r);
    chk("wr045_mdatain", r, 32'h0);
    xfer(1'b0, 9'h045, 32'h0, "rd045", r);
    chk("rd045_data", r, 32'hDEADBEEF);

    // Preload; writes must leave Mdatain alone
    xfer(1'b1, 9'h001, 32'h00000007, "pre001", r);
    chk("pre001_mdatain", r, 32'hDEADBEEF);
    xfer(1'b1, 9'h010, 32'hA5A5A5A5, "pre010", r);
    xfer(1'b1, 9'h020, 32'h11112222, "pre020", r);
    xfer(1'b1, 9'h021, 32'h33334444, "pre021", r);
    chk("pre_mdatain", r, 32'hDEADBEEF);

    // Back-to-back reads with Read held: one pulse every WAIT_STATES+3 edges
    rd = 1'b1; addr = 9'h001;
    cyc = 0; prev = -1; pulses = 0; chk_idle = 1'b0;
    while (pulses < 3 && cyc < 40) begin
      tick();
      cyc++;
      if (chk_idle) begin
        chk("b2b_done_busy", 32'(busy), 32'd0);
        chk_idle = 1'b0;
      end
      if (mem_ready === 1'b1) begin
        chk("b2b_data", mdatain, 32'h00000007);
        if (prev >= 0) chk("b2b_period", 32'(cyc - prev), 32'd5);
        prev = cyc;
        pulses++;
        chk_idle = 1'b1;
      end
    end
    chk("b2b_pulses", 32'(pulses), 32'd3);
    tick();
    rd = 1'b0;
    chk("b2b_end_busy", 32'(busy), 32'd0);
    tick();

    // Illegal request
    rd = 1'b1; wr = 1'b1; addr = 9'h045; din = 32'hFFFFFFFF;
    tick();
    rd = 1'b0; wr = 1'b0;
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_busy", 32'(busy), 32'd0);
    chk("ill_mdatain", mdatain, 32'h00000007);
    tick();
    chk("ill_err_clr", 32'(err), 32'd0);

    // Another illegal request, then clear mid-cycle while err is high
    rd = 1'b1; wr = 1'b1;
    tick();
    rd = 1'b0; wr = 1'b0;
    chk("ill2_err", 32'(err), 32'd1);
    #2 clear = 1'b1;
    #1;
    chk("async_err", 32'(err), 32'd0);
    chk("async_mdatain", mdatain, 32'h0);
    tick();
    clear = 1'b0;
    xfer(1'b0, 9'h045, 32'h0, "rd045b", r);
    chk("rd045b_data", r, 32'hDEADBEEF);

    // Abort a write during WAIT
    wr = 1'b1; addr = 9'h010; din = 32'h12345678;
    tick();
    wr = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    tick();
    #2 clear = 1'b1;
    #1;
    chk("abort_busy_clr", 32'(busy), 32'd0);
    chk("abort_mdatain", mdatain, 32'h0);
    chk("abort_ready", 32'(mem_ready), 32'd0);
    tick();
    tick();
    clear = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_ready === 1'b1) rdy_seen++;
    end
    chk("abort_no_ready", 32'(rdy_seen), 32'd0);
    xfer(1'b0, 9'h010, 32'h0, "rd010", r);
    chk("rd010_data", r, 32'hA5A5A5A5);

    // Address changes and a write strobe while busy are ignored
    rd = 1'b1; addr = 9'h020;
    tick();
    addr = 9'h021; rd = 1'b0; wr = 1'b1; din = 32'h0BADF00D;
    cyc = 0;
    while (mem_ready !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("hold_latency", 32'(cyc), 32'd3);
    chk("hold_data", mdatain, 32'h11112222);
    wr = 1'b0;
    tick();
    xfer(1'b0, 9'h021, 32'h0, "rd021", r);
    chk("rd021_data", r, 32'h33334444);

    // Zero wait states
    wr0 = 1'b1; addr0 = 9'h030; din0 = 32'hCAFEF00D;
    tick();
    wr0 = 1'b0;
    chk("z_wr_busy", 32'(busy0), 32'd1);
    chk("z_wr_rdy_t0", 32'(mem_ready0), 32'd0);
    tick();
    chk("z_wr_rdy", 32'(mem_ready0), 32'd1);
    chk("z_wr_mdatain", mdatain0, 32'h0);
    tick();
    chk("z_wr_done", 32'(mem_ready0), 32'd0);
    chk("z_wr_busy_clr", 32'(busy0), 32'd0);
    rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    tick();
    chk("z_rd_rdy", 32'(mem_ready0), 32'd1);
    chk("z_rd_data", mdatain0, 32'hCAFEF00D);
    tick();
    chk("z_rd_done", 32'(mem_ready0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
